// File: rtl/prio_encoder_rr_if.sv
// Request/result bundle for the round-robin priority encoder.
// The master side drives requests and accepts results; the slave side is the encoder.
interface prio_encoder_rr_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned IDXW = $clog2(N);

  logic [N-1:0]    din;
  logic            mode;
  logic            out_ready;
  logic [IDXW-1:0] y;
  logic            valid;
  logic            multi;
  logic [IDXW-1:0] ptr;

  modport master (
    output din, mode, out_ready,
    input  y, valid, multi, ptr
  );

  modport slave (
    input  din, mode, out_ready,
    output y, valid, multi, ptr
  );
endinterface

// File: rtl/prio_encoder_rr.sv
// Registered priority encoder with fixed or round-robin selection and a one-deep
// valid/ready output hold stage.
module prio_encoder_rr #(
  parameter int unsigned N = 8
) (
  input logic            clk,
  input logic            rst_n,
  prio_encoder_rr_if.slave bus
);
  localparam int unsigned IDXW = $clog2(N);

  typedef enum logic {StIdle, StHold} state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] y_q, y_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic            multi_q, multi_d;
  logic [IDXW-1:0] base;
  logic [IDXW-1:0] sel_idx;
  logic            found;
  logic            accept;
  logic            capture;
  int unsigned     idx;

  always_comb begin
    accept  = (state_q == StHold) && bus.out_ready;
    ptr_d   = ptr_q;
    if (accept) begin
      ptr_d = (y_q == IDXW'(N - 1)) ? '0 : y_q + IDXW'(1);
    end

    // A same-edge recapture searches from the already-advanced pointer.
    base    = bus.mode ? ptr_d : '0;
    sel_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = int'(base) + i;
      if (idx >= N) idx = idx - N;
      if (!found && bus.din[IDXW'(idx)]) begin
        found   = 1'b1;
        sel_idx = IDXW'(idx);
      end
    end

    capture = (bus.din != '0) && ((state_q == StIdle) || accept);
    state_d = state_q;
    y_d     = y_q;
    multi_d = multi_q;
    if (capture) begin
      state_d = StHold;
      y_d     = sel_idx;
      multi_d = (bus.din & (bus.din - N'(1))) != '0;
    end else if (accept) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      y_q     <= '0;
      ptr_q   <= '0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      ptr_q   <= ptr_d;
      multi_q <= multi_d;
    end
  end

  assign bus.valid = (state_q == StHold);
  assign bus.y     = y_q;
  assign bus.multi = multi_q;
  assign bus.ptr   = ptr_q;
endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench for prio_encoder_rr with N=8; expectations are queued as stimulus
// is driven and popped after the sampling edge.
module tb_prio_encoder_rr;
  logic clk;
  logic rst_n;

  prio_encoder_rr_if #(.N(8)) bus ();

  prio_encoder_rr #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed as {valid, y[2:0], multi, ptr[2:0]}.
  logic [7:0] sb[$];
  logic [7:0] got;
  logic [7:0] exp_v;
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic logic [7:0] pk(input logic v, input logic [2:0] y, input logic m,
                                    input logic [2:0] p);
    return {v, y, m, p};
  endfunction

  task automatic drive(input logic [7:0] d, input logic md, input logic rdy);
    bus.din       = d;
    bus.mode      = md;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.din = '0;
    bus.mode = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.din = 8'hff;
    bus.mode = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    got = {bus.valid, bus.y, bus.multi, bus.ptr};
    n_checks++;
    if (got !== pk(1'b0, 3'd0, 1'b0, 3'd0)) begin
      n_fail++;
      $display("FAIL reset_async: got %b required %b", got, pk(1'b0, 3'd0, 1'b0, 3'd0));
    end
    sb.push_back(pk(1'b0, 3'd0, 1'b0, 3'd0));
    drive(8'hff, 1'b1, 1'b1);
    got = {bus.valid, bus.y, bus.multi, bus.ptr};
    exp_v = sb.pop_front();
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL reset_clocked: got %b required %b", got, exp_v);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fixed_single();
    logic [7:0] dins [4] = '{8'h01, 8'h02, 8'h04, 8'h80};
    logic [2:0] ys   [4] = '{3'd0, 3'd1, 3'd2, 3'd7};
    logic [2:0] p;
    do_reset();
    p = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) p = ys[i-1] + 3'd1;
      sb.push_back(pk(1'b1, ys[i], 1'b0, p));
      drive(dins[i], 1'b0, 1'b1);
      got = {bus.valid, bus.y, bus.multi, bus.ptr};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL fixed_single[%0d]: got %b required %b", i, got, exp_v);
      end
    end
    // Accept y=7 with no new request: ptr wraps to 0, back to idle.
    sb.push_back(pk(1'b0, 3'd7, 1'b0, 3'd0));
    drive(8'h00, 1'b0, 1'b1);
    got = {bus.valid, bus.y, bus.multi, bus.ptr};
    exp_v = sb.pop_front();
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL fixed_single_drain: got %b required %b", got, exp_v);
    end
  endtask

  task automatic test_fixed_multi();
    logic [7:0] dins [2] = '{8'h94, 8'h00};
    logic [7:0] exps [2];
    exps[0] = pk(1'b1, 3'd2, 1'b1, 3'd0);
    exps[1] = pk(1'b0, 3'd2, 1'b1, 3'd3);
    do_reset();
    for (int i = 0; i < 2; i++) begin
      sb.push_back(exps[i]);
      drive(dins[i], 1'b0, 1'b1);
      got = {bus.valid, bus.y, bus.multi, bus.ptr};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL fixed_multi[%0d]: got %b required %b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ys [6] = '{3'd0, 3'd2, 3'd7, 3'd0, 3'd2, 3'd7};
    logic [2:0] ps [6] = '{3'd0, 3'd1, 3'd3, 3'd0, 3'd1, 3'd3};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      sb.push_back(pk(1'b1, ys[i], 1'b1, ps[i]));
      drive(8'h85, 1'b1, 1'b1);
      got = {bus.valid, bus.y, bus.multi, bus.ptr};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL rr_back_to_back[%0d]: got %b required %b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    sb.push_back(pk(1'b1, 3'd4, 1'b0, 3'd0));
    drive(8'h10, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) sb.push_back(pk(1'b1, 3'd4, 1'b0, 3'd0));
      if (i > 0) drive(8'($urandom) | 8'h01, 1'(i), 1'b0);
      got = {bus.valid, bus.y, bus.multi, bus.ptr};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got %b required %b", i, got, exp_v);
      end
    end
    sb.push_back(pk(1'b0, 3'd4, 1'b0, 3'd5));
    drive(8'h00, 1'b1, 1'b1);
    got = {bus.valid, bus.y, bus.multi, bus.ptr};
    exp_v = sb.pop_front();
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL backpressure_release: got %b required %b", got, exp_v);
    end
  endtask

  task automatic test_idle_ready();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sb.push_back(pk(1'b0, 3'd0, 1'b0, 3'd0));
      drive(8'h00, 1'(i >> 1), 1'(i));
      got = {bus.valid, bus.y, bus.multi, bus.ptr};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL idle_ready[%0d]: got %b required %b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_reset_in_hold();
    logic [7:0] dins [3] = '{8'h04, 8'h40, 8'h00};
    logic       rdys [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] exps [3];
    exps[0] = pk(1'b1, 3'd2, 1'b0, 3'd0);
    exps[1] = pk(1'b1, 3'd6, 1'b0, 3'd3);
    exps[2] = pk(1'b1, 3'd6, 1'b0, 3'd3);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sb.push_back(exps[i]);
      drive(dins[i], 1'b0, rdys[i]);
      got = {bus.valid, bus.y, bus.multi, bus.ptr};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL hold_setup[%0d]: got %b required %b", i, got, exp_v);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = {bus.valid, bus.y, bus.multi, bus.ptr};
    n_checks++;
    if (got !== pk(1'b0, 3'd0, 1'b0, 3'd0)) begin
      n_fail++;
      $display("FAIL reset_in_hold: got %b required %b", got, pk(1'b0, 3'd0, 1'b0, 3'd0));
    end
    #1;
    rst_n = 1'b1;
    // First edge after reset behaves as idle with ptr=0: rr picks bit >= 0.
    sb.push_back(pk(1'b1, 3'd1, 1'b1, 3'd0));
    drive(8'h0a, 1'b1, 1'b1);
    got = {bus.valid, bus.y, bus.multi, bus.ptr};
    exp_v = sb.pop_front();
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL post_reset_capture: got %b required %b", got, exp_v);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fixed_single();
    test_fixed_multi();
    test_back_to_back();
    test_backpressure();
    test_idle_ready();
    test_reset_in_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
